// File: rtl/gpu_pkg.sv
// Shared encodings and widths for the compute core's scheduler and fetcher.
package gpu_pkg;

  localparam int PC_BITS    = 8;
  localparam int INSTR_BITS = 16;

  // Scheduler core_state encodings
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // Fetcher progress encodings reported back to the scheduler
  localparam logic [2:0] FETCHER_IDLE = 3'b000;
  localparam logic [2:0] FETCHING     = 3'b001;
  localparam logic [2:0] FETCHED      = 3'b010;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: valid/tag/data arrays, combinational
// lookup, single write port and whole-cache flush.
module icache_dm #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int LINES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  logic [IDX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0] lookup_tag;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] wr_tag;

  assign lookup_idx = lookup_addr[IDX_BITS-1:0];
  assign lookup_tag = lookup_addr[ADDR_BITS-1:IDX_BITS];
  assign wr_idx     = wr_addr[IDX_BITS-1:0];
  assign wr_tag     = wr_addr[ADDR_BITS-1:IDX_BITS];

  assign hit   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign rdata = data_q[lookup_idx];

  // Valid bits: flush beats a same-edge fill so a flushed line stays invalid
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data storage is only meaningful under a set valid bit, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/cached_fetcher.sv
// Instruction fetcher answering the scheduler's FETCH handshake, with a
// direct-mapped cache in front of the program-memory read channel.
module cached_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 4,
  parameter int STAT_BITS             = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [STAT_BITS-1:0]             hit_count,
  output logic [STAT_BITS-1:0]             miss_count
);

  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_rdata;
  logic                             fill_en;
  logic                             fill_kill;
  logic                             lookup_hit;

  function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
    return (&v) ? v : v + {{(STAT_BITS-1){1'b0}}, 1'b1};
  endfunction

  // A flush on the lookup edge forces a miss even if the line was valid
  assign lookup_hit = cache_hit && !flush;
  // A flush seen earlier in this fetch (fill_kill) or on the fill edge
  // (handled in the cache) keeps the returned line out of the cache
  assign fill_en    = (fetcher_state == FETCHING) && mem_read_ready && !fill_kill;

  icache_dm #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .rdata       (cache_rdata),
    .wr_en       (fill_en),
    .wr_addr     (mem_read_address),
    .wr_data     (mem_read_data)
  );

  // Fetch FSM with registered handshake outputs and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      fetcher_state    <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      fill_kill        <= 1'b0;
    end else begin
      case (fetcher_state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lookup_hit) begin
              instruction   <= cache_rdata;
              fetcher_state <= FETCHED;
              hit_count     <= sat_inc(hit_count);
            end else begin
              fetcher_state    <= FETCHING;
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              miss_count       <= sat_inc(miss_count);
              fill_kill        <= 1'b0;
            end
          end
        end
        FETCHING: begin
          if (flush) fill_kill <= 1'b1;
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            fetcher_state  <= FETCHED;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) fetcher_state <= FETCHER_IDLE;
        end
        default: begin
          fetcher_state  <= FETCHER_IDLE;
          mem_read_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cached_fetcher.sv
// Directed bench for cached_fetcher: a 16-bit-counter instance and a
// 2-bit-counter instance share the same stimulus.
module tb_cached_fetcher;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  core_state = CORE_IDLE;
  logic [7:0]  current_pc = 8'h00;
  logic        flush = 1'b0;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;

  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count, miss_count;

  logic        s_valid;
  logic [7:0]  s_addr;
  logic [2:0]  s_state;
  logic [15:0] s_instr;
  logic [1:0]  s_hits, s_miss;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  cached_fetcher #(.STAT_BITS(16)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .flush(flush), .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cached_fetcher #(.STAT_BITS(2)) dut_sat (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .flush(flush), .mem_read_valid(s_valid), .mem_read_address(s_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(s_state), .instruction(s_instr),
    .hit_count(s_hits), .miss_count(s_miss)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One FETCH/DECODE round trip; memory answers lat cycles after the request
  task automatic do_fetch(input logic [7:0] pc, input logic [15:0] mdata, input int lat,
                          input bit flush_at_lookup, output bit went_mem,
                          output bit addr_ok, output bit fetched_o,
                          output logic [15:0] instr_o);
    core_state = CORE_FETCH;
    current_pc = pc;
    flush = flush_at_lookup;
    tick;
    flush = 1'b0;
    went_mem = mem_read_valid;
    addr_ok = 1'b1;
    if (went_mem) begin
      addr_ok = (mem_read_address == pc) && (fetcher_state == FETCHING);
      for (int i = 1; i < lat; i++) begin
        tick;
        if (!(mem_read_valid && mem_read_address == pc)) addr_ok = 1'b0;
      end
      mem_read_data = mdata;
      mem_read_ready = 1'b1;
      tick;
      mem_read_ready = 1'b0;
    end
    fetched_o = (fetcher_state == FETCHED);
    instr_o = instruction;
    core_state = CORE_DECODE;
    tick;
    core_state = CORE_IDLE;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++;
    if (fetcher_state !== FETCHER_IDLE || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 ||
        instruction !== 16'h0000 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: state=%b valid=%b addr=%h instr=%h hits=%0d miss=%0d, expected all zero",
               fetcher_state, mem_read_valid, mem_read_address, instruction, hit_count, miss_count);
    end
  endtask

  task automatic test_cold_miss;
    bit wm, ok, fd;
    logic [15:0] ins;
    do_fetch(8'h05, 16'hA1B2, 3, 1'b0, wm, ok, fd, ins);
    exp_miss++;
    checks++;
    if (!(wm && ok)) begin
      errors++;
      $display("FAIL cold_req: went_mem=%b addr_held=%b, expected 1 1", wm, ok);
    end
    checks++;
    if (!fd || ins !== 16'hA1B2) begin
      errors++;
      $display("FAIL cold_data: fetched=%b instr=%h, expected 1 a1b2", fd, ins);
    end
    checks++;
    if (fetcher_state !== FETCHER_IDLE || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL cold_after: state=%b miss=%0d, expected 000 1", fetcher_state, miss_count);
    end
  endtask

  task automatic test_warm_hit;
    bit wm, ok, fd;
    logic [15:0] ins;
    do_fetch(8'h05, 16'hDEAD, 3, 1'b0, wm, ok, fd, ins);
    exp_hits++;
    checks++;
    if (wm || !fd || ins !== 16'hA1B2 || hit_count !== 16'd1) begin
      errors++;
      $display("FAIL warm_hit: went_mem=%b fetched=%b instr=%h hits=%0d, expected 0 1 a1b2 1",
               wm, fd, ins, hit_count);
    end
  endtask

  task automatic test_conflict;
    bit wm1, wm2, wm3, ok, fd;
    logic [15:0] ins1, ins2, ins3;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    do_fetch(8'h05, 16'h1111, 2, 1'b0, wm1, ok, fd, ins1);
    do_fetch(8'h09, 16'h2222, 2, 1'b0, wm2, ok, fd, ins2);
    do_fetch(8'h05, 16'h3333, 2, 1'b0, wm3, ok, fd, ins3);
    exp_miss += 3;
    checks++;
    if (!(wm1 && wm2 && wm3) || miss_count !== 16'(exp_miss)) begin
      errors++;
      $display("FAIL conflict_miss: misses=%b%b%b count=%0d, expected 111 %0d",
               wm1, wm2, wm3, miss_count, exp_miss);
    end
    checks++;
    if (ins2 !== 16'h2222 || ins3 !== 16'h3333) begin
      errors++;
      $display("FAIL conflict_data: %h %h, expected 2222 3333", ins2, ins3);
    end
  endtask

  task automatic test_flush;
    bit wm, ok, fd;
    logic [15:0] ins;
    do_fetch(8'h05, 16'hBAD0, 2, 1'b0, wm, ok, fd, ins);
    exp_hits++;
    checks++;
    if (wm || ins !== 16'h3333) begin
      errors++;
      $display("FAIL flush_prehit: went_mem=%b instr=%h, expected 0 3333", wm, ins);
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    do_fetch(8'h05, 16'h4444, 2, 1'b0, wm, ok, fd, ins);
    exp_miss++;
    checks++;
    if (!wm || ins !== 16'h4444) begin
      errors++;
      $display("FAIL flush_idle: went_mem=%b instr=%h, expected 1 4444", wm, ins);
    end
    // Flush while the request for 06 is outstanding
    core_state = CORE_FETCH; current_pc = 8'h06;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    mem_read_data = 16'h6666; mem_read_ready = 1'b1;
    tick;
    mem_read_ready = 1'b0;
    exp_miss++;
    checks++;
    if (fetcher_state !== FETCHED || instruction !== 16'h6666) begin
      errors++;
      $display("FAIL flush_midfetch: state=%b instr=%h, expected 010 6666", fetcher_state, instruction);
    end
    core_state = CORE_DECODE; tick; core_state = CORE_IDLE;
    do_fetch(8'h06, 16'h6667, 2, 1'b0, wm, ok, fd, ins);
    exp_miss++;
    checks++;
    if (!wm || ins !== 16'h6667) begin
      errors++;
      $display("FAIL flush_midfetch_refetch: went_mem=%b instr=%h, expected 1 6667", wm, ins);
    end
    // Flush on the same edge as the fill for 07
    core_state = CORE_FETCH; current_pc = 8'h07;
    tick;
    mem_read_data = 16'h7777; mem_read_ready = 1'b1; flush = 1'b1;
    tick;
    mem_read_ready = 1'b0; flush = 1'b0;
    exp_miss++;
    checks++;
    if (fetcher_state !== FETCHED || instruction !== 16'h7777) begin
      errors++;
      $display("FAIL flush_fill: state=%b instr=%h, expected 010 7777", fetcher_state, instruction);
    end
    core_state = CORE_DECODE; tick; core_state = CORE_IDLE;
    do_fetch(8'h07, 16'h7778, 2, 1'b0, wm, ok, fd, ins);
    exp_miss++;
    checks++;
    if (!wm || ins !== 16'h7778) begin
      errors++;
      $display("FAIL flush_fill_refetch: went_mem=%b instr=%h, expected 1 7778", wm, ins);
    end
    // 07 is now cached; flush on the lookup edge forces a miss, refill is kept
    do_fetch(8'h07, 16'h7779, 2, 1'b1, wm, ok, fd, ins);
    exp_miss++;
    do_fetch(8'h07, 16'hBAD1, 2, 1'b0, fd, ok, fd, ins);
    exp_hits++;
    checks++;
    if (!wm || ins !== 16'h7779 || hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_miss)) begin
      errors++;
      $display("FAIL flush_lookup: went_mem=%b instr=%h hits=%0d miss=%0d, expected 1 7779 %0d %0d",
               wm, ins, hit_count, miss_count, exp_hits, exp_miss);
    end
  endtask

  task automatic test_hold;
    core_state = CORE_FETCH; current_pc = 8'h30;
    tick;
    mem_read_data = 16'hBEEF; mem_read_ready = 1'b1;
    tick;
    mem_read_ready = 1'b0; mem_read_data = 16'h0BAD;
    exp_miss++;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (fetcher_state !== FETCHED || mem_read_valid !== 1'b0 || instruction !== 16'hBEEF ||
          miss_count !== 16'(exp_miss)) begin
        errors++;
        $display("FAIL hold[%0d]: state=%b valid=%b instr=%h miss=%0d, expected 010 0 beef %0d",
                 i, fetcher_state, mem_read_valid, instruction, miss_count, exp_miss);
      end
    end
    core_state = CORE_DECODE;
    tick;
    core_state = CORE_IDLE;
    checks++;
    if (fetcher_state !== FETCHER_IDLE) begin
      errors++;
      $display("FAIL hold_release: state=%b, expected 000", fetcher_state);
    end
  endtask

  task automatic test_saturation;
    bit wm, ok, fd;
    logic [15:0] ins;
    for (int i = 0; i < 5; i++) begin
      do_fetch(8'h30, 16'h0BAD, 2, 1'b0, wm, ok, fd, ins);
      exp_hits++;
    end
    checks++;
    if (hit_count !== 16'(exp_hits) || s_hits !== 2'd3 || s_miss !== 2'd3 || ins !== 16'hBEEF) begin
      errors++;
      $display("FAIL saturation: hits=%0d sat_hits=%0d sat_miss=%0d instr=%h, expected %0d 3 3 beef",
               hit_count, s_hits, s_miss, ins, exp_hits);
    end
  endtask

  task automatic test_reset_midfetch;
    bit wm, ok, fd;
    logic [15:0] ins;
    core_state = CORE_FETCH; current_pc = 8'h40;
    tick;
    reset = 1'b1; core_state = CORE_IDLE;
    tick;
    reset = 1'b0;
    checks++;
    if (fetcher_state !== FETCHER_IDLE || mem_read_valid !== 1'b0 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: state=%b valid=%b hits=%0d, expected 000 0 0",
               fetcher_state, mem_read_valid, hit_count);
    end
    mem_read_data = 16'h4040; mem_read_ready = 1'b1;
    tick;
    mem_read_ready = 1'b0;
    checks++;
    if (fetcher_state !== FETCHER_IDLE || mem_read_valid !== 1'b0 || instruction !== 16'h0000) begin
      errors++;
      $display("FAIL late_ready: state=%b valid=%b instr=%h, expected 000 0 0000",
               fetcher_state, mem_read_valid, instruction);
    end
    do_fetch(8'h30, 16'h3030, 2, 1'b0, wm, ok, fd, ins);
    checks++;
    if (!wm || ins !== 16'h3030 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_invalidates: went_mem=%b instr=%h miss=%0d, expected 1 3030 1",
               wm, ins, miss_count);
    end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_warm_hit;
    test_conflict;
    test_flush;
    test_hold;
    test_saturation;
    test_reset_midfetch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
